// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Owns the program counter, fetches
//               16-bit instructions over a req/ack handshake into an
//               instruction register, presents decoded fields downstream and
//               applies the BNE target on a taken-branch consume.
//               ADDR_W is expected to be in the range 1..32.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  output logic [3:0]        op_code,
  output logic [2:0]        rs,
  output logic [2:0]        rt,
  output logic [2:0]        rd,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal_op
);

  localparam logic [3:0] c_OP_BNE = 4'hE;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [15:0]       ir_q;
  logic              req_q;
  logic              valid_q;
  logic              halted_q;
  logic              illegal_q;

  logic [ADDR_W-1:0] w_pc_seq;
  logic [ADDR_W-1:0] w_br_off;
  logic              w_take_branch;
  logic              w_rdata_legal;

  // Opcode legality of the word arriving from memory
  always_comb begin
    w_rdata_legal = 1'b0;
    case (imem_rdata[15:12])
      4'h0, 4'h1, 4'h2, 4'h6,
      4'h7, 4'h8, 4'hA, 4'hE: w_rdata_legal = 1'b1;
      default:                w_rdata_legal = 1'b0;
    endcase
  end

  // Next PC: sequential, or sequential plus the sign-extended 6-bit offset
  // when a BNE is consumed with its condition true. Arithmetic wraps.
  always_comb begin
    w_pc_seq      = pc_q + ADDR_W'(1);
    w_br_off      = ADDR_W'($signed(ir_q[5:0]));
    w_take_branch = (ir_q[15:12] == c_OP_BNE) && branch_taken;
    pc_d          = w_take_branch ? (w_pc_seq + w_br_off) : w_pc_seq;
  end

  // Fetch/issue/halt sequencer; all handshake and status outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= ADDR_W'(RESET_PC);
      ir_q      <= 16'h0000;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          // An ack only counts while the request is actually on the bus,
          // so a stray ack in the cycle right after reset is ignored.
          if (req_q && imem_ack) begin
            ir_q  <= imem_rdata;
            req_q <= 1'b0;
            if (w_rdata_legal) begin
              state_q <= ST_ISSUE;
              valid_q <= 1'b1;
            end else begin
              state_q   <= ST_HALT;
              halted_q  <= 1'b1;
              illegal_q <= 1'b1;
            end
          end else begin
            req_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            pc_q    <= pc_d;
            state_q <= ST_FETCH;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end
        end
        ST_HALT: begin
          req_q    <= 1'b0;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign illegal_op  = illegal_q;
  assign op_code     = ir_q[15:12];
  assign rs          = ir_q[11:9];
  assign rt          = ir_q[8:6];
  assign rd          = ir_q[5:3];
  assign imm         = {{10{ir_q[5]}}, ir_q[5:0]};

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: directed vector table,
//               hand-written corner sequences and a randomized run against a
//               cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int ADDR_W   = 8;
  localparam int RESET_PC = 0;
  localparam int AMASK    = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_taken;
  logic [3:0]        op_code;
  logic [2:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              illegal_op;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken),
    .op_code(op_code), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .pc(pc), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst_first;
    logic [7:0]  vpc;
    logic [15:0] instr;
    bit          taken;
    logic [3:0]  op;
    logic [2:0]  vrs, vrt, vrd;
    logic [15:0] vimm;
    logic [7:0]  next;
  } vec_t;

  vec_t tbl [16];

  // Reference model state
  int          m_pc;
  bit          m_req, m_valid, m_halt;
  logic [15:0] m_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit r, input logic [7:0] p, input logic [15:0] i,
                              input bit t, input logic [3:0] o, input logic [2:0] a,
                              input logic [2:0] b, input logic [2:0] c,
                              input logic [15:0] m, input logic [7:0] n);
    vec_t v;
    v.rst_first = r; v.vpc = p; v.instr = i; v.taken = t; v.op = o;
    v.vrs = a; v.vrt = b; v.vrd = c; v.vimm = m; v.next = n;
    return v;
  endfunction

  function automatic bit legal_op(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE};
  endfunction

  function automatic int sext6(input logic [5:0] v);
    return v[5] ? int'(v) - 64 : int'(v);
  endfunction

  // One clock: present memory data for the current address, then sample #1 after the edge
  task automatic step();
    imem_rdata = mem[imem_addr];
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_req = 0; m_valid = 0; m_halt = 0; m_ir = 16'h0;
  endtask

  task automatic model_edge(input bit ack, input bit rdy, input bit tkn);
    if (m_halt) begin
      // stays halted until reset
    end else if (m_valid) begin
      if (rdy) begin
        m_pc = (m_pc + 1 + ((m_ir[15:12] == 4'hE && tkn) ? sext6(m_ir[5:0]) : 0)) & AMASK;
        m_valid = 0;
        m_req = 1;
      end
    end else if (m_req && ack) begin
      m_ir = mem[m_pc];
      m_req = 0;
      if (legal_op(m_ir[15:12])) m_valid = 1;
      else m_halt = 1;
    end else begin
      m_req = 1;
    end
  endtask

  task automatic compare_model();
    check("rnd_req", {31'd0, imem_req}, {31'd0, m_req});
    check("rnd_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    check("rnd_halted", {31'd0, halted}, {31'd0, m_halt});
    check("rnd_illegal", {31'd0, illegal_op}, {31'd0, m_halt});
    check("rnd_addr", {24'd0, imem_addr}, 32'(m_pc));
    check("rnd_pc", {24'd0, pc}, 32'(m_pc));
    if (m_valid)
      check("rnd_fields", {3'd0, op_code, rs, rt, rd, imm},
            {3'd0, m_ir[15:12], m_ir[11:9], m_ir[8:6], m_ir[5:3], 16'(sext6(m_ir[5:0]))});
  endtask

  // Called #1 after an edge; releases reset #1 after a later edge
  task automatic apply_reset();
    rst = 1'b1;
    imem_ack = 0; instr_ready = 0; branch_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_rec(input vec_t v);
    if (v.rst_first) apply_reset();
    mem[v.vpc] = v.instr;
    imem_ack = 1; instr_ready = 0; branch_taken = 0;
    for (int n = 0; n < 10 && !instr_valid; n++) step();
    check("rec_valid", {31'd0, instr_valid}, 32'd1);
    check("rec_pc", {24'd0, pc}, {24'd0, v.vpc});
    check("rec_op", {28'd0, op_code}, {28'd0, v.op});
    check("rec_regs", {23'd0, rs, rt, rd}, {23'd0, v.vrs, v.vrt, v.vrd});
    check("rec_imm", {16'd0, imm}, {16'd0, v.vimm});
    imem_ack = 0; instr_ready = 1; branch_taken = v.taken;
    step();
    check("rec_next_req", {31'd0, imem_req}, 32'd1);
    check("rec_next_addr", {24'd0, imem_addr}, {24'd0, v.next});
    check("rec_next_valid", {31'd0, instr_valid}, 32'd0);
    instr_ready = 0; branch_taken = 0;
  endtask

  initial begin
    logic [3:0] legal_list [8];
    int halt_cnt;
    bit a, r, t;

    legal_list = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE};

    tbl[0]  = mk(1, 8'h00, 16'h2A5F, 0, 4'h2, 3'd5, 3'd1, 3'd3, 16'h001F, 8'h01);
    tbl[1]  = mk(0, 8'h01, 16'hE03E, 0, 4'hE, 3'd0, 3'd0, 3'd7, 16'hFFFE, 8'h02);
    tbl[2]  = mk(0, 8'h02, 16'hE03E, 1, 4'hE, 3'd0, 3'd0, 3'd7, 16'hFFFE, 8'h01);
    tbl[3]  = mk(0, 8'h01, 16'h8FC1, 1, 4'h8, 3'd7, 3'd7, 3'd0, 16'h0001, 8'h02);
    tbl[4]  = mk(0, 8'h02, 16'hE001, 1, 4'hE, 3'd0, 3'd0, 3'd0, 16'h0001, 8'h04);
    tbl[5]  = mk(0, 8'h04, 16'h0000, 0, 4'h0, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h05);
    tbl[6]  = mk(0, 8'h05, 16'hE03E, 1, 4'hE, 3'd0, 3'd0, 3'd7, 16'hFFFE, 8'h04);
    tbl[7]  = mk(0, 8'h04, 16'h7E38, 0, 4'h7, 3'd7, 3'd0, 3'd7, 16'hFFF8, 8'h05);
    tbl[8]  = mk(0, 8'h05, 16'hE03E, 0, 4'hE, 3'd0, 3'd0, 3'd7, 16'hFFFE, 8'h06);
    tbl[9]  = mk(0, 8'h06, 16'hA020, 1, 4'hA, 3'd0, 3'd0, 3'd4, 16'hFFE0, 8'h07);
    tbl[10] = mk(0, 8'h07, 16'h61C7, 0, 4'h6, 3'd0, 3'd7, 3'd0, 16'h0007, 8'h08);
    tbl[11] = mk(0, 8'h08, 16'h1249, 1, 4'h1, 3'd1, 3'd1, 3'd1, 16'h0009, 8'h09);
    tbl[12] = mk(1, 8'h00, 16'hE03E, 1, 4'hE, 3'd0, 3'd0, 3'd7, 16'hFFFE, 8'hFF);
    tbl[13] = mk(0, 8'hFF, 16'h2000, 1, 4'h2, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h00);
    tbl[14] = mk(0, 8'h00, 16'hE03D, 1, 4'hE, 3'd0, 3'd0, 3'd7, 16'hFFFD, 8'hFE);
    tbl[15] = mk(0, 8'hFE, 16'hE001, 1, 4'hE, 3'd0, 3'd0, 3'd0, 16'h0001, 8'h00);

    // Reset state and sequential fetch with ack and ready tied high
    for (int i = 0; i < 256; i++) mem[i] = 16'h2000;
    rst = 1'b1; imem_ack = 0; instr_ready = 0; branch_taken = 0; imem_rdata = 16'h0;
    #2;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    check("rst_pc", {24'd0, pc}, RESET_PC);
    check("rst_ir", {16'd0, op_code, rs, rt, rd, imm[2:0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    imem_ack = 1; instr_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("seq_req", {31'd0, imem_req}, 32'(k % 2));
      check("seq_valid", {31'd0, instr_valid}, 32'((k + 1) % 2));
      check("seq_addr", {24'd0, imem_addr}, 32'((k - 1) / 2));
    end

    // Directed vector table: field decode, BNE taken/not-taken, wrap-around
    for (int i = 0; i < 16; i++) run_rec(tbl[i]);

    // Wait states then backpressure; pc is 0 and a fetch is pending here
    mem[0] = 16'h7123;
    imem_ack = 0; instr_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", {24'd0, imem_addr}, 32'd0);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1;
    step();
    imem_ack = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      check("bp_op", {28'd0, op_code}, 32'h7);
      check("bp_imm", {16'd0, imm}, 32'h0000FFE3);
      check("bp_pc", {24'd0, pc}, 32'd0);
    end
    instr_ready = 1;
    step();
    instr_ready = 0;
    for (int k = 0; k < 3; k++) begin
      check("bp_one_inc", {24'd0, pc}, 32'd1);
      step();
    end

    // Illegal opcode at pc=7 reached through a taken branch
    apply_reset();
    mem[7] = 16'h3000;
    run_rec(mk(0, 8'h00, 16'hE006, 1, 4'hE, 3'd0, 3'd0, 3'd0, 16'h0006, 8'h07));
    imem_ack = 1;
    step();
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_flag", {31'd0, illegal_op}, 32'd1);
    check("ill_valid", {31'd0, instr_valid}, 32'd0);
    check("ill_req", {31'd0, imem_req}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      imem_ack = 1'($urandom); instr_ready = 1'($urandom); branch_taken = 1'($urandom);
      step();
      check("halt_pc", {24'd0, pc}, 32'd7);
      check("halt_state", {29'd0, halted, illegal_op, instr_valid}, 32'b110);
    end

    // Asynchronous reset between edges while a fetch with ack is in flight
    apply_reset();
    mem[0] = 16'h2000;
    mem[1] = 16'h6000;
    run_rec(mk(0, 8'h00, 16'h2000, 0, 4'h2, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h01));
    imem_ack = 1;
    imem_rdata = mem[1];
    #3;
    rst = 1'b1;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_pc", {24'd0, pc}, RESET_PC);
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("arst_resume_req", {31'd0, imem_req}, 32'd1);
    check("arst_resume_addr", {24'd0, imem_addr}, RESET_PC);
    step();
    check("arst_resume_valid", {31'd0, instr_valid}, 32'd1);
    check("arst_resume_op", {28'd0, op_code}, 32'h2);

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 63) == 0) ? 4'h3 + 4'($urandom_range(0, 1)) : legal_list[$urandom_range(0, 7)];
      mem[i] = {op, 12'($urandom)};
    end
    apply_reset();
    halt_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      a = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      t = 1'($urandom);
      imem_ack = a; instr_ready = r; branch_taken = t;
      model_edge(a, r, t);
      step();
      compare_model();
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
      if (halt_cnt > 6) begin
        apply_reset();
        halt_cnt = 0;
      end else if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_model();
        apply_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
